// File: rtl/mul_fx_pkg.sv
// Shared types and default geometry for the mul_fx serial fixed-point multiplier.
// Optional rounding is selected with MUL_FX_ROUND_EN (see mul_fx_round).
package mul_fx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH = 24;
    localparam int unsigned DEF_FBITS = 23;

endpackage

// File: rtl/mul_fx_round.sv
// Extracts the fixed-point result field from the full product and flags overflow.
// MUL_FX_ROUND_EN defined: round half up on bit FBITS-1; otherwise truncate.
module mul_fx_round
    import mul_fx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FBITS = DEF_FBITS
) (
    input  logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   res,
    output logic               ovf
);

    logic [WIDTH-1:0] field;
    logic             hi_ovf;

    assign field  = prod[WIDTH+FBITS-1:FBITS];
    assign hi_ovf = |prod[2*WIDTH-1:WIDTH+FBITS];

    // Bits below the result field only matter when rounding consumes the top one.
    if (FBITS > 0) begin : g_low
        logic unused_low;
        assign unused_low = ^prod[FBITS-1:0];
    end

`ifdef MUL_FX_ROUND_EN
    logic           rbit;
    logic [WIDTH:0] rsum;

    if (FBITS > 0) begin : g_rbit
        assign rbit = prod[FBITS-1];
    end else begin : g_nobit
        assign rbit = 1'b0;
    end

    assign rsum = {1'b0, field} + {{WIDTH{1'b0}}, rbit};
    assign res  = rsum[WIDTH-1:0];
    assign ovf  = hi_ovf | rsum[WIDTH];
`else
    assign res = field;
    assign ovf = hi_ovf;
`endif

endmodule

// File: rtl/mul_fx.sv
// Radix-2 shift-add unsigned fixed-point multiplier, one multiplier bit per cycle.
// Result rounding is controlled by MUL_FX_ROUND_EN inside mul_fx_round.
module mul_fx
    import mul_fx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FBITS = DEF_FBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             valid,
    output logic             ovf,
    output logic             zero,
    output logic [WIDTH-1:0] p
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   xr, yr;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [CW-1:0]      cnt;
    logic               last;
    logic [WIDTH:0]     psum;
    logic [2*WIDTH:0]   wide;
    logic [WIDTH-1:0]   rres;
    logic               rovf;

    assign last = (cnt == CW'(WIDTH - 1));

    // Add into the upper half with carry, then shift the whole accumulator right.
    always_comb begin
        psum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (yr[0] ? {1'b0, xr} : '0);
        wide   = {psum, acc[WIDTH-1:0]};
        acc_nx = wide[2*WIDTH:1];
    end

    mul_fx_round #(
        .WIDTH(WIDTH),
        .FBITS(FBITS)
    ) u_round (
        .prod(acc_nx),
        .res (rres),
        .ovf (rovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start)
            state_nx = CALC;
        else if (state == CALC && last)
            state_nx = IDLE;
    end

    always_comb begin
        busy = (state == CALC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr    <= '0;
            yr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
            p     <= '0;
        end else if (start) begin
            xr    <= x;
            yr    <= y;
            acc   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (state == CALC) begin
            acc <= acc_nx;
            yr  <= yr >> 1;
            cnt <= cnt + CW'(1);
            // The final iteration's sum is evaluated directly so results land with busy dropping.
            if (last) begin
                if (rovf) begin
                    ovf   <= 1'b1;
                    valid <= 1'b0;
                    zero  <= 1'b0;
                    p     <= '0;
                end else begin
                    ovf   <= 1'b0;
                    valid <= 1'b1;
                    zero  <= (rres == '0);
                    p     <= rres;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_fx.sv
// Self-checking bench for mul_fx: directed corner cases plus randomized operands
// against an arithmetic reference model.
module tb_mul_fx;

    localparam int unsigned W = 24;
    localparam int unsigned F = 23;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  x, y;
    logic          busy, valid, ovf, zero;
    logic [W-1:0]  p;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    mul_fx #(
        .WIDTH(W),
        .FBITS(F)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .x    (x),
        .y    (y),
        .busy (busy),
        .valid(valid),
        .ovf  (ovf),
        .zero (zero),
        .p    (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact product by plain multiplication, then field/overflow/rounding rules.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] ep, output logic ev,
                         output logic eo, output logic ez);
        longint unsigned prod, field;
        logic            of;
        prod  = longint'(a) * longint'(b);
        field = (prod >> F) & ((64'd1 << W) - 1);
        of    = (prod >> (W + F)) != 0;
`ifdef MUL_FX_ROUND_EN
        if (F > 0) field = field + ((prod >> (F - 1)) & 64'd1);
        if ((field >> W) != 0) of = 1'b1;
`endif
        if (of) begin
            ep = '0; ev = 1'b0; eo = 1'b1; ez = 1'b0;
        end else begin
            ep = field[W-1:0]; ev = 1'b1; eo = 1'b0; ez = (field == 0);
        end
    endtask

    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        x     = a;
        y     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = $urandom;
        y     = $urandom;
    endtask

    task automatic wait_done(output int cyc, output bit saw_valid);
        cyc       = 0;
        saw_valid = 1'b0;
        while (busy && cyc < 100) begin
            if (valid) saw_valid = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int           cyc;
        bit           sv;
        logic [W-1:0] ep;
        logic         ev, eo, ez;
        model(a, b, ep, ev, eo, ez);
        pulse_start(a, b);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        wait_done(cyc, sv);
        check({tag, ".lat"}, 32'(cyc), 32'(W));
        check({tag, ".early_valid"}, 32'(sv), 32'd0);
        check({tag, ".valid"}, 32'(valid), 32'(ev));
        check({tag, ".ovf"}, 32'(ovf), 32'(eo));
        check({tag, ".zero"}, 32'(zero), 32'(ez));
        check({tag, ".p"}, 32'(p), 32'(ep));
    endtask

    initial begin
        int           cyc;
        bit           sv;
        logic [W-1:0] a, b, ep;
        logic         ev, eo, ez;

        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.state", {27'd0, busy, valid, ovf, zero, |p}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 * 1.0
        run_op("one_x_one", 24'h800000, 24'h800000);
        check("one_x_one.p_const", 32'(p), 32'h800000);
        // 1.5 * 1.5 overflows the integer part
        run_op("ovf", 24'hC00000, 24'hC00000);
        check("ovf.flag_const", 32'(ovf), 32'd1);
        // exactly half an LSB
        run_op("half_lsb", 24'h000001, 24'h400000);
`ifdef MUL_FX_ROUND_EN
        check("half_lsb.p_const", 32'(p), 32'h000001);
`else
        check("half_lsb.p_const", 32'(p), 32'h000000);
`endif
        // zero operand keeps full latency
        run_op("zero_op", 24'h000000, 24'hFFFFFF);
        check("zero_op.zero_const", 32'(zero), 32'd1);
        run_op("max_max", 24'hFFFFFF, 24'hFFFFFF);
        run_op("small", 24'h000003, 24'h000002);

        // Results hold through idle cycles
        repeat (7) @(posedge clk);
        #1;
        model(24'h000003, 24'h000002, ep, ev, eo, ez);
        check("hold.p", 32'(p), 32'(ep));
        check("hold.valid", 32'(valid), 32'(ev));

        // Restart mid-operation: first job must never produce a valid
        pulse_start(24'h800000, 24'h400000);
        sv = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (valid) sv = 1'b1;
        end
        pulse_start(24'h400000, 24'h400000);
        wait_done(cyc, ev);
        check("restart.early_valid", 32'(sv | ev), 32'd0);
        check("restart.lat", 32'(cyc), 32'(W));
        check("restart.p", 32'(p), 32'h200000);
        check("restart.valid", 32'(valid), 32'd1);

        // Asynchronous reset mid-calculation
        pulse_start(24'h123456, 24'h654321);
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.now", {27'd0, busy, valid, ovf, zero, |p}, 32'd0);
        @(negedge clk);
        start = 1'b1;
        x     = 24'h800000;
        y     = 24'h800000;
        @(posedge clk);
        #1;
        check("areset.start_ignored", 32'(busy), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sv = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if ({busy, valid, ovf, zero, |p} != 5'd0) sv = 1'b1;
        end
        check("areset.quiet40", 32'(sv), 32'd0);

        // Randomized operands, scaled down by random shifts to cover both outcomes
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom) >> $urandom_range(0, 12);
            b = W'($urandom) >> $urandom_range(0, 12);
            run_op($sformatf("rand%0d", i), a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
